// File: rtl/img_rx_writer.sv
// Streams valid/ready pixel beats into image SRAM at raster (row, col, channel) addresses.
// Zero-latency write path; optional sticky overrun flag under IMG_RX_OVERRUN_EN.
module img_rx_writer #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 8,
  parameter int NCH    = 1,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [ROW_W-1:0]  row_last,
  input  logic [COL_W-1:0]  col_last,
  input  logic              col_major,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              sram_se,
  output logic              sram_we,
  output logic [CH_W-1:0]   sram_bank,
  output logic [ROW_W-1:0]  sram_row,
  output logic [COL_W-1:0]  sram_col,
  output logic [DATA_W-1:0] sram_din
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

  state_t           state, state_nxt;
  logic [CH_W-1:0]  ch, ch_nxt;
  logic [ROW_W-1:0] row, row_nxt, rl_q, rl_nxt;
  logic [COL_W-1:0] col, col_nxt, cl_q, cl_nxt;
  logic             cm_q, cm_nxt;
  logic             beat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ch    <= '0;
      row   <= '0;
      col   <= '0;
      rl_q  <= '0;
      cl_q  <= '0;
      cm_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      rl_q  <= rl_nxt;
      cl_q  <= cl_nxt;
      cm_q  <= cm_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    row_nxt   = row;
    col_nxt   = col;
    rl_nxt    = rl_q;
    cl_nxt    = cl_q;
    cm_nxt    = cm_q;
    beat      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    s_ready   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          rl_nxt    = row_last;
          cl_nxt    = col_last;
          cm_nxt    = col_major;
          ch_nxt    = '0;
          row_nxt   = '0;
          col_nxt   = '0;
        end
      end
      RUN: begin
        busy    = 1'b1;
        s_ready = ~abort;
        beat    = s_valid & ~abort;
        if (beat) begin
          if (ch != CH_LAST) begin
            ch_nxt = ch + CH_W'(1);
          end else begin
            ch_nxt = '0;
            if (row == rl_q && col == cl_q) begin
              state_nxt = DONE;
              row_nxt   = '0;
              col_nxt   = '0;
            end else if (!cm_q) begin
              // row-major: column is the fast index
              if (col == cl_q) begin
                col_nxt = '0;
                row_nxt = row + ROW_W'(1);
              end else begin
                col_nxt = col + COL_W'(1);
              end
            end else begin
              if (row == rl_q) begin
                row_nxt = '0;
                col_nxt = col + COL_W'(1);
              end else begin
                row_nxt = row + ROW_W'(1);
              end
            end
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // abort outranks start and any in-flight beat
    if (abort) begin
      state_nxt = IDLE;
      ch_nxt    = '0;
      row_nxt   = '0;
      col_nxt   = '0;
    end
  end

  assign sram_se   = 1'b1;
  assign sram_we   = beat;
  assign sram_bank = ch;
  assign sram_row  = row;
  assign sram_col  = col;
  assign sram_din  = s_data;

`ifdef IMG_RX_OVERRUN_EN
  logic start_acc;
  logic ovr_q;

  assign start_acc = (state == IDLE) & start & ~abort;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovr_q <= 1'b0;
    end else if (start_acc) begin
      ovr_q <= 1'b0;
    end else if (s_valid && state != RUN && !start) begin
      ovr_q <= 1'b1;
    end
  end

  assign overrun = ovr_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_img_rx_writer.sv
// Bench for img_rx_writer: NCH=1 and NCH=3 instances checked every cycle against a beat-index address model.
module tb_img_rx_writer;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic       start_s[2], abort_s[2], cm_s[2], valid_s[2];
  logic [7:0] rl_s[2], cl_s[2], data_s[2];
  logic       ready_o[2], busy_o[2], done_o[2], ovr_o[2], se_o[2], we_o[2];
  logic [7:0] row_o[2], col_o[2], din_o[2];
  logic [0:0] bank1;
  logic [1:0] bank3;

  img_rx_writer #(.DATA_W(8), .ROW_W(8), .COL_W(8), .NCH(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start_s[0]), .abort(abort_s[0]),
    .row_last(rl_s[0]), .col_last(cl_s[0]), .col_major(cm_s[0]),
    .s_valid(valid_s[0]), .s_data(data_s[0]), .s_ready(ready_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .overrun(ovr_o[0]),
    .sram_se(se_o[0]), .sram_we(we_o[0]), .sram_bank(bank1),
    .sram_row(row_o[0]), .sram_col(col_o[0]), .sram_din(din_o[0]));

  img_rx_writer #(.DATA_W(8), .ROW_W(8), .COL_W(8), .NCH(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .start(start_s[1]), .abort(abort_s[1]),
    .row_last(rl_s[1]), .col_last(cl_s[1]), .col_major(cm_s[1]),
    .s_valid(valid_s[1]), .s_data(data_s[1]), .s_ready(ready_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .overrun(ovr_o[1]),
    .sram_se(se_o[1]), .sram_we(we_o[1]), .sram_bank(bank3),
    .sram_row(row_o[1]), .sram_col(col_o[1]), .sram_din(din_o[1]));

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // model: frame state (0 idle, 1 run, 2 done), beats taken, latched config
  int mst[2], mk[2], mrl[2], mcl[2];
  bit mcm[2], mov[2];
  int done_cnt[2];
  int log0[$], log1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic void exp_addr(input int d, input int kk, output int ch, output int r, output int c);
    int p;
    ch = kk % nch(d);
    p  = kk / nch(d);
    if (mcm[d]) begin
      r = p % (mrl[d] + 1);
      c = p / (mrl[d] + 1);
    end else begin
      c = p % (mcl[d] + 1);
      r = p / (mcl[d] + 1);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        int ech, er_, ec, bk, st0;
        bit rdy;
        bk  = (d == 0) ? 32'(bank1) : 32'(bank3);
        st0 = mst[d];
        rdy = (st0 == 1) && !abort_s[d];
        chk("s_ready", 32'(ready_o[d]), 32'(rdy));
        chk("busy", 32'(busy_o[d]), 32'(st0 == 1));
        chk("done", 32'(done_o[d]), 32'(st0 == 2));
        chk("sram_we", 32'(we_o[d]), 32'(rdy && valid_s[d]));
        chk("sram_se", 32'(se_o[d]), 32'd1);
`ifdef IMG_RX_OVERRUN_EN
        chk("overrun", 32'(ovr_o[d]), 32'(mov[d]));
`else
        chk("overrun", 32'(ovr_o[d]), 32'd0);
`endif
        if (rdy && valid_s[d]) begin
          exp_addr(d, mk[d], ech, er_, ec);
          chk("bank", 32'(bk), 32'(ech));
          chk("row", 32'(row_o[d]), 32'(er_));
          chk("col", 32'(col_o[d]), 32'(ec));
          chk("din", 32'(din_o[d]), 32'(data_s[d]));
        end
        if (we_o[d]) begin
          if (d == 0) log0.push_back((bk << 16) | (32'(row_o[d]) << 8) | 32'(col_o[d]));
          else        log1.push_back((bk << 16) | (32'(row_o[d]) << 8) | 32'(col_o[d]));
        end
        if (done_o[d]) done_cnt[d]++;

        if (st0 == 0 && start_s[d] && !abort_s[d]) mov[d] = 1'b0;
        else if (valid_s[d] && st0 != 1 && !start_s[d]) mov[d] = 1'b1;

        if (abort_s[d]) begin
          mst[d] = 0;
          mk[d]  = 0;
        end else begin
          case (st0)
            0: if (start_s[d]) begin
              mst[d] = 1; mk[d] = 0;
              mrl[d] = int'(rl_s[d]); mcl[d] = int'(cl_s[d]); mcm[d] = cm_s[d];
            end
            1: if (valid_s[d]) begin
              mk[d]++;
              if (mk[d] == (mrl[d] + 1) * (mcl[d] + 1) * nch(d)) mst[d] = 2;
            end
            default: mst[d] = 0;
          endcase
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    done_cnt[0] = 0;
    done_cnt[1] = 0;
  endtask

  task automatic frame(input int d, input int rl, input int cl, input bit cm, input int pct, input bit rnd_start);
    int n;
    rl_s[d] = 8'(rl); cl_s[d] = 8'(cl); cm_s[d] = cm;
    start_s[d] = 1'b1; valid_s[d] = 1'b0;
    cyc();
    start_s[d] = 1'b0;
    // scramble config to show it is only sampled on the start cycle
    rl_s[d] = 8'($urandom); cl_s[d] = 8'($urandom); cm_s[d] = 1'($urandom);
    n = 0;
    while (mst[d] != 0 && n < 3000) begin
      valid_s[d] = ($urandom_range(99) < pct);
      data_s[d]  = 8'($urandom);
      start_s[d] = rnd_start && ($urandom_range(9) == 0);
      cyc();
      n++;
    end
    valid_s[d] = 1'b0;
    start_s[d] = 1'b0;
    chk("frame_complete", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    int exp_t1[6];
    int exp_t3[6];
    int exp_t5[4];
    int dups;
    bit seen[256];

    for (int d = 0; d < 2; d++) begin
      mst[d] = 0; mk[d] = 0; mrl[d] = 0; mcl[d] = 0; mcm[d] = 0; mov[d] = 0; done_cnt[d] = 0;
      start_s[d] = 1'b1; abort_s[d] = 1'b0; cm_s[d] = 1'b1; valid_s[d] = 1'b1;
      rl_s[d] = 8'd5; cl_s[d] = 8'd5; data_s[d] = 8'hA5;
    end

    // reset values with live-looking inputs
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", 32'(busy_o[d]), 32'd0);
      chk("rst_done", 32'(done_o[d]), 32'd0);
      chk("rst_ready", 32'(ready_o[d]), 32'd0);
      chk("rst_ovr", 32'(ovr_o[d]), 32'd0);
      chk("rst_we", 32'(we_o[d]), 32'd0);
      chk("rst_row", 32'(row_o[d]), 32'd0);
      chk("rst_col", 32'(col_o[d]), 32'd0);
    end
    chk("rst_bank3", 32'(bank3), 32'd0);
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; valid_s[d] = 1'b0; cm_s[d] = 1'b0;
    end
    cyc();
    rstn = 1'b1;
    chk_on = 1'b1;
    cyc();

    // 2x3 row-major, NCH=1, continuous stream
    clear_logs();
    frame(0, 1, 2, 1'b0, 100, 1'b0);
    exp_t1 = '{32'h000, 32'h001, 32'h002, 32'h100, 32'h101, 32'h102};
    chk("t1_count", 32'(log0.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < log0.size()) chk("t1_addr", 32'(log0[i]), 32'(exp_t1[i]));
    chk("t1_done", 32'(done_cnt[0]), 32'd1);

    // NCH=3 interleave, 1x2 frame
    clear_logs();
    frame(1, 0, 1, 1'b0, 100, 1'b0);
    exp_t3 = '{32'h00000, 32'h10000, 32'h20000, 32'h00001, 32'h10001, 32'h20001};
    chk("t2_count", 32'(log1.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < log1.size()) chk("t2_bank_col", 32'(log1[i]), 32'(exp_t3[i]));

    // column-major 3x2
    clear_logs();
    frame(0, 2, 1, 1'b1, 100, 1'b0);
    exp_t1 = '{32'h000, 32'h100, 32'h200, 32'h001, 32'h101, 32'h201};
    chk("t3_count", 32'(log0.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < log0.size()) chk("t3_addr", 32'(log0[i]), 32'(exp_t1[i]));

    // 4x4 with ~50% valid gaps
    clear_logs();
    frame(0, 3, 3, 1'b0, 50, 1'b0);
    chk("t4_count", 32'(log0.size()), 32'd16);
    dups = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    foreach (log0[i]) begin
      if (seen[log0[i] & 32'hFF | ((log0[i] >> 8) & 32'hF) << 4]) dups++;
      seen[log0[i] & 32'hFF | ((log0[i] >> 8) & 32'hF) << 4] = 1'b1;
    end
    chk("t4_dups", 32'(dups), 32'd0);
    chk("t4_done", 32'(done_cnt[0]), 32'd1);

    // abort on the 3rd beat of a 2x2 frame
    clear_logs();
    rl_s[0] = 8'd1; cl_s[0] = 8'd1; cm_s[0] = 1'b0; start_s[0] = 1'b1;
    cyc();
    start_s[0] = 1'b0; valid_s[0] = 1'b1; data_s[0] = 8'h11;
    cyc();
    data_s[0] = 8'h22;
    cyc();
    abort_s[0] = 1'b1; data_s[0] = 8'h33;
    cyc();
    abort_s[0] = 1'b0; valid_s[0] = 1'b0;
    chk("t5_busy_after_abort", 32'(busy_o[0]), 32'd0);
    chk("t5_writes", 32'(log0.size()), 32'd2);
    cyc();
    chk("t5_no_done", 32'(done_cnt[0]), 32'd0);
    clear_logs();
    frame(0, 1, 1, 1'b0, 100, 1'b0);
    exp_t5 = '{32'h000, 32'h001, 32'h100, 32'h101};
    chk("t5_refill_count", 32'(log0.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < log0.size()) chk("t5_refill_addr", 32'(log0[i]), 32'(exp_t5[i]));

    // data offered while idle is dropped; start+abort together stays idle
    clear_logs();
    valid_s[0] = 1'b1;
    repeat (3) cyc();
    valid_s[0] = 1'b0;
`ifdef IMG_RX_OVERRUN_EN
    chk("t6_ovr_set", 32'(ovr_o[0]), 32'd1);
`else
    chk("t6_ovr_off", 32'(ovr_o[0]), 32'd0);
`endif
    chk("t6_dropped", 32'(log0.size()), 32'd0);
    start_s[0] = 1'b1; abort_s[0] = 1'b1;
    cyc();
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    chk("t6_start_abort_idle", 32'(busy_o[0]), 32'd0);
    // 1x1 frame: one beat, then done
    rl_s[0] = 8'd0; cl_s[0] = 8'd0; start_s[0] = 1'b1;
    cyc();
    start_s[0] = 1'b0;
    chk("t6_ovr_cleared", 32'(ovr_o[0]), 32'd0);
    valid_s[0] = 1'b1;
    cyc();
    valid_s[0] = 1'b0;
    chk("t6_done_pulse", 32'(done_o[0]), 32'd1);
    cyc();
    chk("t6_done_end", 32'(done_o[0]), 32'd0);
    chk("t6_writes", 32'(log0.size()), 32'd1);

    // random frames on the 3-channel instance with stray starts
    for (int t = 0; t < 6; t++) begin
      clear_logs();
      frame(1, $urandom_range(3), $urandom_range(3), 1'($urandom), 55, 1'b1);
      chk("rnd_done", 32'(done_cnt[1]), 32'd1);
    end

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
